// File: rtl/layer_controller_input_loader.sv
`default_nettype none
// layer_controller_input_loader: Avalon-MM master that writes a streamed input vector into per-input PIO
// registers and optionally reads each one back to verify it.  Rev 1.0
module layer_controller_input_loader #(
  parameter int NUM_INPUTS  = 4,
  parameter int DATA_W      = 9,
  parameter int ADDR_W      = 8,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_STRIDE = 16,
  parameter int VERIFY      = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic              avm_read,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int c_IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_INPUTS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [c_IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic                error_q, error_d;
  logic [ADDR_W-1:0]   w_addr;
  logic [31:0]         w_wdata;

  // Address arithmetic is done at ADDR_W so it wraps modulo 2^ADDR_W.
  assign w_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q) * ADDR_W'(ADDR_STRIDE);
  assign w_wdata = 32'(val_q);
  assign error   = error_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      val_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    val_d         = val_q;
    error_d       = error_q;
    busy          = 1'b1;
    done          = 1'b0;
    s_ready       = 1'b0;
    avm_write     = 1'b0;
    avm_read      = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          error_d = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        s_ready = 1'b1;
        if (s_valid) begin
          val_d   = s_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        avm_write     = 1'b1;
        avm_address   = w_addr;
        avm_writedata = w_wdata;
        if (!avm_waitrequest) begin
          if (VERIFY != 0) state_d = READ;
          else             state_d = NEXT;
        end
      end
      READ: begin
        avm_read    = 1'b1;
        avm_address = w_addr;
        // Upper readback bits must be zero as well, so compare the full word.
        if (!avm_waitrequest) begin
          if (avm_readdata != w_wdata) error_d = 1'b1;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (idx_q == c_LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + c_IDX_W'(1);
          state_d = FETCH;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_layer_controller_input_loader.sv
`default_nettype none
// Bench for layer_controller_input_loader: random loads checked against a transaction-level model
// with a wait-state-capable PIO slave.  Rev 1.0
module tb_layer_controller_input_loader;

  localparam int NI     = 4;
  localparam int DW     = 9;
  localparam int AW     = 8;
  localparam int STRIDE = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [31:0]   avm_readdata = '0;
  logic          avm_waitrequest = 1'b0;
  logic          busy, done, error, s_ready, avm_write, avm_read;
  logic [AW-1:0] avm_address;
  logic [31:0]   avm_writedata;

  logic          n_start = 1'b0;
  logic          n_s_valid = 1'b0;
  logic [DW-1:0] n_s_data = '0;
  logic [31:0]   n_avm_readdata = '0;
  logic          n_avm_waitrequest = 1'b0;
  logic          n_busy, n_done, n_error, n_s_ready, n_avm_write, n_avm_read;
  logic [AW-1:0] n_avm_address;
  logic [31:0]   n_avm_writedata;

  layer_controller_input_loader u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .error(error),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  layer_controller_input_loader #(.VERIFY(0)) u_dut_nv (
    .clk(clk), .reset_n(reset_n), .start(n_start), .busy(n_busy), .done(n_done), .error(n_error),
    .s_valid(n_s_valid), .s_ready(n_s_ready), .s_data(n_s_data),
    .avm_address(n_avm_address), .avm_write(n_avm_write), .avm_read(n_avm_read),
    .avm_writedata(n_avm_writedata), .avm_readdata(n_avm_readdata), .avm_waitrequest(n_avm_waitrequest)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state: the vector being loaded and the transactions seen so far.
  logic [DW-1:0] vals [NI];
  logic [31:0]   mem [256];
  int            wait_n = 0, bad_idx = -1, wr_k = 0, rd_k = 0, wcnt = 0, done_cnt = 0;
  int            cyc = 0, t0 = 0, t_done = 0;
  bit            stall_prev = 0, exp_err = 0, pend_clr = 0, pend_err = 0, pend_rst = 0;
  logic          busy_prev = 1'b0, prev_wr = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [31:0]   prev_wdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and protocol monitor; decisions made here take effect at the next rising edge.
  always @(negedge clk) begin
    if (pend_rst) exp_err = 1'b0;
    if (pend_clr) exp_err = 1'b0;
    if (pend_err) exp_err = 1'b1;
    pend_rst = 0; pend_clr = 0; pend_err = 0;
    check("error_flag", {31'b0, error}, {31'b0, exp_err});
    check("rw_exclusive", {31'b0, avm_read & avm_write}, 0);
    check("s_ready_only_fetch", {31'b0, s_ready & (avm_write | avm_read | ~busy | done)}, 0);
    if (busy && !busy_prev) t0 = cyc;
    if (done) begin t_done = cyc; done_cnt++; end
    busy_prev = busy;
    if (!reset_n) begin
      pend_rst = 1; avm_waitrequest = 1'b0; wcnt = 0; stall_prev = 0;
    end else begin
      if (start && !busy) pend_clr = 1;
      if (avm_write || avm_read) begin
        if (stall_prev) begin
          check("addr_hold", {24'b0, avm_address}, {24'b0, prev_addr});
          check("wdata_hold", avm_writedata, prev_wdata);
          check("cmd_hold", {31'b0, avm_write}, {31'b0, prev_wr});
        end
        if (wcnt < wait_n) begin
          avm_waitrequest = 1'b1; wcnt++; stall_prev = 1;
          prev_addr = avm_address; prev_wdata = avm_writedata; prev_wr = avm_write;
        end else begin
          avm_waitrequest = 1'b0; wcnt = 0; stall_prev = 0;
          if (avm_write) begin
            if (wr_k >= NI) check("extra_write", wr_k, NI - 1);
            else begin
              check("wr_addr", {24'b0, avm_address}, {24'b0, AW'(wr_k * STRIDE)});
              check("wr_data", avm_writedata, {23'b0, vals[wr_k]});
            end
            mem[avm_address] = avm_writedata;
            wr_k++;
          end else begin
            if (rd_k >= NI) check("extra_read", rd_k, NI - 1);
            else begin
              check("rd_addr", {24'b0, avm_address}, {24'b0, AW'(rd_k * STRIDE)});
              avm_readdata = (rd_k == bad_idx) ? 32'h0 : mem[avm_address];
              if (avm_readdata != {23'b0, vals[rd_k]}) pend_err = 1;
            end
            rd_k++;
          end
        end
      end else begin
        if (stall_prev) check("req_dropped_in_stall", 0, 1);
        avm_waitrequest = 1'b0; wcnt = 0; stall_prev = 0;
      end
    end
  end

  logic [31:0] n_wa[$], n_wd[$];
  int          n_reads = 0, n_t0 = 0, n_tdone = 0, n_done_cnt = 0;
  logic        n_busy_prev = 1'b0;

  always @(negedge clk) begin
    if (n_avm_write) begin
      n_wa.push_back({24'b0, n_avm_address});
      n_wd.push_back(n_avm_writedata);
    end
    if (n_avm_read) n_reads++;
    if (n_busy && !n_busy_prev) n_t0 = cyc;
    if (n_done) begin n_tdone = cyc; n_done_cnt++; end
    n_busy_prev = n_busy;
  end

  task automatic run_load(input int wn, input int gmax, input int bad, input bit poke, input bit fixed);
    int  t;
    int  g;
    bit  exp_final;
    if (!fixed) for (int k = 0; k < NI; k++) vals[k] = DW'($urandom);
    if (bad >= 0 && bad < NI && vals[bad] == '0) vals[bad] = DW'(1);
    wait_n = wn; bad_idx = bad; wr_k = 0; rd_k = 0; done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < NI; k++) begin
      g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
      repeat (g) begin @(posedge clk); #1; end
      s_valid = 1'b1; s_data = vals[k];
      if (poke && k == 2) start = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!s_ready && t < 200);
      if (!s_ready) check("s_ready_timeout", 0, 1);
      @(posedge clk); #1 s_valid = 1'b0; start = 1'b0;
    end
    t = 0;
    while (done_cnt == 0 && t < 500) begin @(negedge clk); t++; end
    check("done_seen", done_cnt, 1);
    if (gmax == 0 && !poke) check("latency", t_done - t0, NI * (4 + 2 * wn));
    repeat (4) @(negedge clk);
    exp_final = (bad >= 0 && bad < NI);
    check("done_once", done_cnt, 1);
    check("busy_after", {31'b0, busy}, 0);
    check("write_count", wr_k, NI);
    check("read_count", rd_k, NI);
    check("error_end", {31'b0, error}, {31'b0, exp_final});
  endtask

  initial begin
    int t;
    logic [DW-1:0] n_vals [NI];
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_error", {31'b0, error}, 0);
    check("rst_s_ready", {31'b0, s_ready}, 0);
    check("rst_write", {31'b0, avm_write}, 0);
    check("rst_read", {31'b0, avm_read}, 0);
    check("rst_addr", {24'b0, avm_address}, 0);
    check("rst_wdata", avm_writedata, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Fixed vector, zero-wait slave.
    vals[0] = 9'h001; vals[1] = 9'h0FF; vals[2] = 9'h100; vals[3] = 9'h1FF;
    run_load(0, 0, -1, 0, 1);
    // Three wait states on every access.
    run_load(3, 0, -1, 0, 0);
    // Corrupted readback of input 2, then a clean load clears the flag.
    run_load(0, 0, 2, 0, 0);
    run_load(0, 0, -1, 0, 0);
    // Stream gaps with start poked while busy.
    repeat (3) run_load(0, 5, -1, 1, 0);
    repeat (2) run_load(int'($urandom_range(2, 0)), 3, -1, 0, 0);

    // Reset during a stalled write of input 1.
    for (int k = 0; k < NI; k++) vals[k] = DW'($urandom);
    wait_n = 20; bad_idx = -1; wr_k = 0; rd_k = 0; done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1; s_data = vals[k];
      t = 0;
      do begin @(negedge clk); t++; end while (!s_ready && t < 200);
      if (!s_ready) check("t5_s_ready_timeout", 0, 1);
      @(posedge clk); #1 s_valid = 1'b0;
    end
    t = 0;
    do begin @(negedge clk); t++; end while (!(avm_write && avm_address == 8'h10) && t < 200);
    check("t5_stalled_write", {31'b0, avm_write}, 1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_write_drop", {31'b0, avm_write}, 0);
    check("t5_read", {31'b0, avm_read}, 0);
    check("t5_busy", {31'b0, busy}, 0);
    check("t5_done", {31'b0, done}, 0);
    check("t5_error", {31'b0, error}, 0);
    check("t5_s_ready", {31'b0, s_ready}, 0);
    check("t5_addr", {24'b0, avm_address}, 0);
    check("t5_wdata", avm_writedata, 0);
    check("t5_no_done", done_cnt, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    run_load(0, 0, -1, 0, 0);

    // Write-only instance.
    n_vals[0] = 9'h1AB;
    for (int k = 1; k < NI; k++) n_vals[k] = DW'($urandom);
    @(posedge clk); #1 n_start = 1'b1;
    @(posedge clk); #1 n_start = 1'b0;
    for (int k = 0; k < NI; k++) begin
      n_s_valid = 1'b1; n_s_data = n_vals[k];
      t = 0;
      do begin @(negedge clk); t++; end while (!n_s_ready && t < 200);
      if (!n_s_ready) check("t6_s_ready_timeout", 0, 1);
      @(posedge clk); #1 n_s_valid = 1'b0;
    end
    t = 0;
    while (n_done_cnt == 0 && t < 200) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    check("t6_done_once", n_done_cnt, 1);
    check("t6_latency", n_tdone - n_t0, 3 * NI);
    check("t6_reads", n_reads, 0);
    check("t6_write_count", n_wa.size(), NI);
    if (n_wa.size() == NI) begin
      check("t6_wdata0", n_wd[0], 32'h000001AB);
      for (int k = 0; k < NI; k++) begin
        check("t6_addr", n_wa[k], k * STRIDE);
        check("t6_data", n_wd[k], {23'b0, n_vals[k]});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
